// File: rtl/exc_sched.sv
// exc_sched: exception/interrupt sequencer sitting at the M-stage commit point.
// In IDLE it arbitrates interrupt > exception > ERET. An accepted event pulses
// CP0 (EXL set with code/BD/PC, or EXL clear for ERET), holds flush for
// FLUSH_CYCLES cycles, then pulses pc_redirect towards the handler or the
// sampled EPC. While busy the M-stage inputs are ignored.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   m_valid, m_pc, m_bd   M-stage instruction qualifier, PC, delay-slot flag
//   m_exc_valid/_code     M-stage exception and its ExcCode
//   m_eret                M-stage instruction is ERET
//   intreq                masked CP0 interrupt request
//   epc                   CP0 EPC, sampled when ERET is accepted
//   cp0_exl_set/_clr      one-cycle CP0 EXL set / clear pulses
//   cp0_exc_code/bd/pc    values CP0 latches on cp0_exl_set
//   flush                 kill F/D/E/M and block M-stage writes
//   pc_redirect           one-cycle fetch redirect to redirect_addr
//   busy                  sequence in progress
module exc_sched #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_valid,
  input  logic [31:0] m_pc,
  input  logic        m_bd,
  input  logic        m_exc_valid,
  input  logic [4:0]  m_exc_code,
  input  logic        m_eret,
  input  logic        intreq,
  input  logic [31:0] epc,
  output logic        cp0_exl_set,
  output logic        cp0_exl_clr,
  output logic [4:0]  cp0_exc_code,
  output logic        cp0_bd,
  output logic [29:0] cp0_pc,
  output logic        flush,
  output logic        pc_redirect,
  output logic [31:0] redirect_addr,
  output logic        busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FLUSH = 2'd1;
  localparam logic [1:0] S_REDIR = 2'd2;

  localparam logic [3:0] CNT_LAST = 4'(FLUSH_CYCLES);

  logic [1:0] state;
  logic [3:0] cnt;
  logic       take_int;
  logic       take_exc;
  logic       take_eret;
  logic       pc_low_unused;

  // PC is word aligned; the low bits carry no information for CP0.
  assign pc_low_unused = ^m_pc[1:0];

  always_comb begin
    take_int  = (state == S_IDLE) && m_valid && intreq;
    take_exc  = (state == S_IDLE) && m_valid && !intreq && m_exc_valid;
    take_eret = (state == S_IDLE) && m_valid && !intreq && !m_exc_valid && m_eret;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      cp0_exl_set   <= 1'b0;
      cp0_exl_clr   <= 1'b0;
      cp0_exc_code  <= '0;
      cp0_bd        <= 1'b0;
      cp0_pc        <= '0;
      redirect_addr <= '0;
    end else begin
      cp0_exl_set <= 1'b0;
      cp0_exl_clr <= 1'b0;
      case (state)
        S_IDLE: begin
          if (take_int || take_exc) begin
            // An interrupt takes the M-stage instruction as its victim,
            // so EPC becomes m_pc and any pending exception is flushed.
            cp0_exl_set   <= 1'b1;
            cp0_exc_code  <= take_int ? 5'd0 : m_exc_code;
            cp0_bd        <= m_bd;
            cp0_pc        <= m_pc[31:2];
            redirect_addr <= HANDLER_ADDR;
            state         <= S_FLUSH;
            cnt           <= 4'd1;
          end else if (take_eret) begin
            cp0_exl_clr   <= 1'b1;
            redirect_addr <= epc;
            state         <= S_FLUSH;
            cnt           <= 4'd1;
          end
        end
        S_FLUSH: begin
          if (cnt == CNT_LAST) begin
            state <= S_REDIR;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_REDIR: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign flush       = (state == S_FLUSH);
  assign pc_redirect = (state == S_REDIR);
  assign busy        = (state != S_IDLE);

endmodule
